// File: rtl/life_round_controller.sv
// ---------------------------------------------------------------------------
// life_round_controller
//
// Game-flow sequencer that sits directly downstream of the game-logic top.
// It filters the collision flag, counts remaining lives and steps through
// IDLE -> PLAYING -> DYING -> RESPAWN/GAME_OVER. It drives the round reset
// for the sprites and a freeze flag for the display stage.
//
// Ports
//   clk            system clock, all logic on posedge
//   rst            synchronous, active-high reset
//   pacman_is_dead collision flag from game logic (may glitch)
//   start_btn      start/restart button, level, already synchronised
//   tick_en        one-clk game-tick strobe (frame rate)
//   round_rst      synchronous reset to the game-logic sprites
//   freeze         high whenever state != PLAYING
//   game_active    high in PLAYING
//   game_over      high in GAME_OVER
//   death_pulse    one-cycle strobe on each registered death
//   lives          remaining lives
//   state          IDLE=0, PLAYING=1, DYING=2, RESPAWN=3, GAME_OVER=4
//
// Every output is a flop. The decoded flags are registered from the
// next-state value so they change on the same edge as `state`.
// ---------------------------------------------------------------------------
module life_round_controller #(
  parameter int START_LIVES    = 3,
  parameter int LIVES_W        = 2,
  parameter int HIT_FILTER     = 2,
  parameter int DEATH_TICKS    = 60,
  parameter int RESPAWN_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pacman_is_dead,
  input  logic               start_btn,
  input  logic               tick_en,
  output logic               round_rst,
  output logic               freeze,
  output logic               game_active,
  output logic               game_over,
  output logic               death_pulse,
  output logic [LIVES_W-1:0] lives,
  output logic [2:0]         state
);

  localparam int HIT_W  = $clog2(HIT_FILTER) + 1;
  localparam int TICK_W = $clog2(DEATH_TICKS) + 1;
  localparam int CYC_W  = $clog2(RESPAWN_CYCLES) + 1;

  localparam logic [HIT_W-1:0]   HIT_LAST    = HIT_W'(HIT_FILTER - 1);
  localparam logic [TICK_W-1:0]  TICK_LAST   = TICK_W'(DEATH_TICKS - 1);
  localparam logic [CYC_W-1:0]   CYC_LAST    = CYC_W'(RESPAWN_CYCLES - 1);
  localparam logic [LIVES_W-1:0] LIVES_RESET = LIVES_W'(START_LIVES);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PLAYING   = 3'd1,
    S_DYING     = 3'd2,
    S_RESPAWN   = 3'd3,
    S_GAME_OVER = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [LIVES_W-1:0]  lives_d;
  logic [HIT_W-1:0]    hit_cnt, hit_d;
  logic [TICK_W-1:0]   tick_cnt, tick_d;
  logic [CYC_W-1:0]    cyc_cnt, cyc_d;
  logic                pulse_d;
  logic                start_prev;
  logic                start_edge;

  assign start_edge = start_btn & ~start_prev;
  assign state      = state_q;

  // NOTE: every signal gets its hold/default value before the case so that no
  // path through the block leaves one unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    lives_d = lives;
    hit_d   = hit_cnt;
    tick_d  = tick_cnt;
    cyc_d   = cyc_cnt;
    pulse_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        hit_d  = '0;
        tick_d = '0;
        cyc_d  = '0;
        if (start_edge) state_d = S_PLAYING;
      end

      // A death registers only after HIT_FILTER consecutive high cycles, so
      // single-cycle collision glitches are discarded.
      S_PLAYING: begin
        if (pacman_is_dead) begin
          if (hit_cnt == HIT_LAST) begin
            state_d = S_DYING;
            lives_d = lives - LIVES_W'(1);
            pulse_d = 1'b1;
            hit_d   = '0;
            tick_d  = '0;
          end else begin
            hit_d = hit_cnt + HIT_W'(1);
          end
        end else begin
          hit_d = '0;
        end
      end

      // tick_cnt was cleared on the entry edge, so a tick coincident with
      // entry was seen in PLAYING and is not counted here.
      S_DYING: begin
        if (tick_en) begin
          if (tick_cnt == TICK_LAST) begin
            state_d = (lives == '0) ? S_GAME_OVER : S_RESPAWN;
            tick_d  = '0;
            cyc_d   = '0;
          end else begin
            tick_d = tick_cnt + TICK_W'(1);
          end
        end
      end

      S_RESPAWN: begin
        hit_d = '0;
        if (cyc_cnt == CYC_LAST) begin
          state_d = S_PLAYING;
          cyc_d   = '0;
        end else begin
          cyc_d = cyc_cnt + CYC_W'(1);
        end
      end

      S_GAME_OVER: begin
        if (start_edge) begin
          state_d = S_IDLE;
          lives_d = LIVES_RESET;
        end
      end

      // Encodings 5..7 recover to a clean IDLE.
      default: begin
        state_d = S_IDLE;
        lives_d = LIVES_RESET;
        hit_d   = '0;
        tick_d  = '0;
        cyc_d   = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      lives       <= LIVES_RESET;
      hit_cnt     <= '0;
      tick_cnt    <= '0;
      cyc_cnt     <= '0;
      start_prev  <= 1'b1;  // a button held through reset must not start a game
      death_pulse <= 1'b0;
      round_rst   <= 1'b1;
      freeze      <= 1'b1;
      game_active <= 1'b0;
      game_over   <= 1'b0;
    end else begin
      state_q     <= state_d;
      lives       <= lives_d;
      hit_cnt     <= hit_d;
      tick_cnt    <= tick_d;
      cyc_cnt     <= cyc_d;
      start_prev  <= start_btn;
      death_pulse <= pulse_d;
      round_rst   <= (state_d == S_IDLE) || (state_d == S_RESPAWN);
      freeze      <= (state_d != S_PLAYING);
      game_active <= (state_d == S_PLAYING);
      game_over   <= (state_d == S_GAME_OVER);
    end
  end

endmodule

// File: tb/tb_life_round_controller.sv
// ---------------------------------------------------------------------------
// tb_life_round_controller
//
// Each scenario task builds a stimulus list, drives it one clock at a time,
// pushes the expected post-edge outputs to a scoreboard queue and pops them
// for comparison once the edge has happened. Expected flags are derived from
// the expected state using the output definitions of the block.
// ---------------------------------------------------------------------------
module tb_life_round_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       pacman_is_dead;
  logic       start_btn;
  logic       tick_en;
  logic       round_rst;
  logic       freeze;
  logic       game_active;
  logic       game_over;
  logic       death_pulse;
  logic [1:0] lives;
  logic [2:0] state;

  int n_checks = 0;
  int n_fail   = 0;

  life_round_controller #(
    .START_LIVES    (3),
    .LIVES_W        (2),
    .HIT_FILTER     (2),
    .DEATH_TICKS    (3),
    .RESPAWN_CYCLES (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .pacman_is_dead (pacman_is_dead),
    .start_btn      (start_btn),
    .tick_en        (tick_en),
    .round_rst      (round_rst),
    .freeze         (freeze),
    .game_active    (game_active),
    .game_over      (game_over),
    .death_pulse    (death_pulse),
    .lives          (lives),
    .state          (state)
  );

  always #5 clk = ~clk;

  // Observed vector: {state, lives, round_rst, freeze, game_active, game_over, death_pulse}
  logic [9:0] obs;
  assign obs = {state, lives, round_rst, freeze, game_active, game_over, death_pulse};

  typedef struct packed {
    logic       r;
    logic       b;
    logic       d;
    logic       t;
    logic [2:0] st;
    logic [1:0] lv;
    logic       dp;
  } stim_t;

  logic [9:0] sb_q[$];

  function automatic stim_t mk(input logic r, input logic b, input logic d, input logic t,
                               input logic [2:0] st, input logic [1:0] lv, input logic dp);
    stim_t s;
    s.r = r; s.b = b; s.d = d; s.t = t; s.st = st; s.lv = lv; s.dp = dp;
    return s;
  endfunction

  function automatic logic [9:0] expv(input logic [2:0] st, input logic [1:0] lv, input logic dp);
    return {st, lv, (st == 3'd0) || (st == 3'd3), (st != 3'd1), (st == 3'd1), (st == 3'd4), dp};
  endfunction

  // Drives one cycle of inputs and records what the outputs must be after the edge.
  task automatic drive(input stim_t s);
    rst            = s.r;
    start_btn      = s.b;
    pacman_is_dead = s.d;
    tick_en        = s.t;
    sb_q.push_back(expv(s.st, s.lv, s.dp));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    stim_t      s[$];
    logic [9:0] want;
    s.push_back(mk(1, 1, 0, 0, 3'd0, 2'd3, 0));
    s.push_back(mk(1, 1, 0, 1, 3'd0, 2'd3, 0));
    s.push_back(mk(0, 1, 0, 0, 3'd0, 2'd3, 0));  // held through reset: no start
    s.push_back(mk(0, 1, 0, 1, 3'd0, 2'd3, 0));
    s.push_back(mk(0, 0, 0, 0, 3'd0, 2'd3, 0));
    s.push_back(mk(0, 0, 1, 0, 3'd0, 2'd3, 0));
    s.push_back(mk(0, 1, 0, 0, 3'd1, 2'd3, 0));  // press
    s.push_back(mk(0, 1, 0, 0, 3'd1, 2'd3, 0));
    s.push_back(mk(0, 0, 0, 0, 3'd1, 2'd3, 0));
    foreach (s[i]) begin
      drive(s[i]);
      want = sb_q.pop_front();
      n_checks++;
      if (obs !== want) begin
        n_fail++;
        $display("FAIL test_reset[%0d]: got %b, want %b", i, obs, want);
      end
    end
  endtask

  task automatic test_glitch_filter();
    stim_t      s[$];
    logic [9:0] want;
    for (int k = 0; k < 3; k++) begin
      s.push_back(mk(0, 0, 1, 0, 3'd1, 2'd3, 0));
      s.push_back(mk(0, 0, 0, 0, 3'd1, 2'd3, 0));
    end
    s.push_back(mk(0, 1, 0, 1, 3'd1, 2'd3, 0));  // start edge and tick ignored
    s.push_back(mk(0, 0, 0, 0, 3'd1, 2'd3, 0));
    foreach (s[i]) begin
      drive(s[i]);
      want = sb_q.pop_front();
      n_checks++;
      if (obs !== want) begin
        n_fail++;
        $display("FAIL test_glitch_filter[%0d]: got %b, want %b", i, obs, want);
      end
    end
  endtask

  task automatic test_death_respawn();
    stim_t      s[$];
    logic [9:0] want;
    s.push_back(mk(0, 0, 1, 0, 3'd1, 2'd3, 0));
    s.push_back(mk(0, 0, 1, 1, 3'd2, 2'd2, 1));  // death edge, tick here not counted
    s.push_back(mk(0, 0, 1, 0, 3'd2, 2'd2, 0));
    s.push_back(mk(0, 0, 0, 1, 3'd2, 2'd2, 0));  // tick 1
    s.push_back(mk(0, 0, 0, 0, 3'd2, 2'd2, 0));
    s.push_back(mk(0, 0, 0, 1, 3'd2, 2'd2, 0));  // tick 2
    s.push_back(mk(0, 0, 0, 0, 3'd2, 2'd2, 0));
    s.push_back(mk(0, 0, 0, 1, 3'd3, 2'd2, 0));  // tick 3 -> RESPAWN
    s.push_back(mk(0, 0, 1, 0, 3'd3, 2'd2, 0));
    s.push_back(mk(0, 0, 1, 0, 3'd3, 2'd2, 0));
    s.push_back(mk(0, 0, 0, 1, 3'd3, 2'd2, 0));
    s.push_back(mk(0, 0, 0, 0, 3'd1, 2'd2, 0));  // 4 cycles of round_rst done
    s.push_back(mk(0, 0, 1, 0, 3'd1, 2'd2, 0));  // hit count restarted from 0
    s.push_back(mk(0, 0, 0, 0, 3'd1, 2'd2, 0));
    foreach (s[i]) begin
      drive(s[i]);
      want = sb_q.pop_front();
      n_checks++;
      if (obs !== want) begin
        n_fail++;
        $display("FAIL test_death_respawn[%0d]: got %b, want %b", i, obs, want);
      end
    end
  endtask

  task automatic test_game_over();
    stim_t      s[$];
    logic [9:0] want;
    s.push_back(mk(0, 0, 1, 0, 3'd1, 2'd2, 0));
    s.push_back(mk(0, 0, 1, 0, 3'd2, 2'd1, 1));
    s.push_back(mk(0, 0, 0, 1, 3'd2, 2'd1, 0));
    s.push_back(mk(0, 0, 0, 1, 3'd2, 2'd1, 0));
    s.push_back(mk(0, 0, 0, 1, 3'd3, 2'd1, 0));
    s.push_back(mk(0, 0, 0, 0, 3'd3, 2'd1, 0));
    s.push_back(mk(0, 0, 0, 0, 3'd3, 2'd1, 0));
    s.push_back(mk(0, 0, 0, 0, 3'd3, 2'd1, 0));
    s.push_back(mk(0, 0, 0, 0, 3'd1, 2'd1, 0));
    s.push_back(mk(0, 0, 1, 0, 3'd1, 2'd1, 0));
    s.push_back(mk(0, 0, 1, 0, 3'd2, 2'd0, 1));  // last life lost
    s.push_back(mk(0, 0, 0, 1, 3'd2, 2'd0, 0));
    s.push_back(mk(0, 0, 0, 1, 3'd2, 2'd0, 0));
    s.push_back(mk(0, 0, 0, 1, 3'd4, 2'd0, 0));  // GAME_OVER
    s.push_back(mk(0, 0, 1, 1, 3'd4, 2'd0, 0));
    s.push_back(mk(0, 1, 0, 0, 3'd0, 2'd3, 0));  // restart -> IDLE, lives reloaded
    s.push_back(mk(0, 1, 0, 0, 3'd0, 2'd3, 0));
    s.push_back(mk(0, 0, 0, 0, 3'd0, 2'd3, 0));
    foreach (s[i]) begin
      drive(s[i]);
      want = sb_q.pop_front();
      n_checks++;
      if (obs !== want) begin
        n_fail++;
        $display("FAIL test_game_over[%0d]: got %b, want %b", i, obs, want);
      end
    end
  endtask

  task automatic test_reset_mid();
    stim_t      s[$];
    logic [9:0] want;
    s.push_back(mk(0, 1, 0, 0, 3'd1, 2'd3, 0));
    s.push_back(mk(0, 0, 1, 0, 3'd1, 2'd3, 0));
    s.push_back(mk(0, 0, 1, 0, 3'd2, 2'd2, 1));
    s.push_back(mk(0, 0, 0, 1, 3'd2, 2'd2, 0));
    s.push_back(mk(0, 0, 0, 1, 3'd2, 2'd2, 0));
    s.push_back(mk(0, 0, 0, 1, 3'd3, 2'd2, 0));  // RESPAWN, cyc_cnt=0
    s.push_back(mk(0, 0, 0, 0, 3'd3, 2'd2, 0));  // cyc_cnt=1
    s.push_back(mk(0, 0, 0, 0, 3'd3, 2'd2, 0));  // cyc_cnt=2
    s.push_back(mk(1, 0, 0, 0, 3'd0, 2'd3, 0));  // reset mid RESPAWN
    s.push_back(mk(0, 1, 0, 0, 3'd0, 2'd3, 0));  // start_prev reloaded to 1: no start
    s.push_back(mk(0, 0, 0, 0, 3'd0, 2'd3, 0));
    s.push_back(mk(0, 1, 0, 0, 3'd1, 2'd3, 0));
    s.push_back(mk(0, 0, 1, 0, 3'd1, 2'd3, 0));
    s.push_back(mk(1, 0, 1, 0, 3'd0, 2'd3, 0));  // reset on the death edge drops the pulse
    s.push_back(mk(0, 0, 0, 0, 3'd0, 2'd3, 0));
    foreach (s[i]) begin
      drive(s[i]);
      want = sb_q.pop_front();
      n_checks++;
      if (obs !== want) begin
        n_fail++;
        $display("FAIL test_reset_mid[%0d]: got %b, want %b", i, obs, want);
      end
    end
  endtask

  initial begin
    rst            = 1'b1;
    start_btn      = 1'b1;
    pacman_is_dead = 1'b0;
    tick_en        = 1'b0;
    test_reset();
    test_glitch_filter();
    test_death_respawn();
    test_game_over();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "timeout");
  end

endmodule
